// File: rtl/rr_enc_pkg.sv
// Shared types and helpers for the round-robin 8:3 encoder.
// Holds widths, the request/index types, the FSM state and bit-rotation helpers.
package rr_enc_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N-1:0]     req_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // Rotate right so that bit 'sh' of r lands at bit 0.
  function automatic req_t rotr(input req_t r, input idx_t sh);
    req_t rot;
    idx_t j;
    rot = '0;
    for (int i = 0; i < int'(N); i++) begin
      j      = idx_t'(i) + sh;
      rot[i] = r[j];
    end
    return rot;
  endfunction

  function automatic req_t onehot(input idx_t i);
    req_t g;
    g    = '0;
    g[i] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/rr_encoder8_3_pri.sv
// Fixed-priority 8:3 encoder: index of the lowest set input bit plus an any flag.
// Purely combinational.
module pri_encoder8_3
  import rr_enc_pkg::*;
(
  input  logic [N-1:0]     in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |in_i;
    // Walk downward so the lowest set bit is the final assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/rr_encoder8_3.sv
// Round-robin 8:3 encoder with a registered, handshake-held grant.
// The search starts at ptr; an accepted requester drops to lowest priority.
module rr_encoder8_3
  import rr_enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     grant
);

  state_e state_q, state_d;
  idx_t   ptr_q, ptr_d;
  idx_t   idx_q, idx_d;
  req_t   grant_q, grant_d;

  req_t   req_rot;
  idx_t   enc_idx;
  logic   enc_any;
  logic   accept;
  logic   load;

  assign accept  = (state_q == GRANT) && ack;
  // The pointer moves on acceptance, and the moved pointer steers the same-edge reload.
  assign ptr_d   = accept ? idx_q + idx_t'(1) : ptr_q;
  assign req_rot = rotr(req, ptr_d);

  pri_encoder8_3 u_pri (
    .in_i  (req_rot),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign load = enc_any && ((state_q == IDLE) || accept);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    if (load) begin
      state_d = GRANT;
      idx_d   = enc_idx + ptr_d;
      grant_d = onehot(enc_idx + ptr_d);
    end else if (accept) begin
      state_d = IDLE;
      idx_d   = '0;
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign valid = (state_q == GRANT);
  assign idx   = idx_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_rr_encoder8_3.sv
// Self-checking bench for rr_encoder8_3: directed cases with literal expectations,
// then random traffic compared every cycle against a behavioural round-robin model.
module tb_rr_encoder8_3;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       ack;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] grant;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int m_valid;
  int m_idx;
  int m_ptr;

  rr_encoder8_3 dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ack   (ack),
    .valid (valid),
    .idx   (idx),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_in_order(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (m_valid == 1 && ack) begin
      m_ptr = (m_idx + 1) % 8;
      if (req != 8'h00) begin
        m_idx = first_in_order(req, m_ptr);
      end else begin
        m_valid = 0;
        m_idx   = 0;
      end
    end else if (m_valid == 0 && req != 8'h00) begin
      m_valid = 1;
      m_idx   = first_in_order(req, m_ptr);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_valid", int'(valid), m_valid);
    chk("model_idx", int'(idx), m_idx);
    chk("model_grant", int'(grant), (m_valid == 1) ? (1 << m_idx) : 0);
    chk("invariant", int'(grant), valid ? (1 << idx) : 0);
  end

  task automatic step(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int v, input int i, input int g);
    chk({name, "_valid"}, int'(valid), v);
    chk({name, "_idx"}, int'(idx), i);
    chk({name, "_grant"}, int'(grant), g);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  int exp_seq[9];

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    ack   = 1'b0;
    @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 8'h00);
    reset = 1'b0;

    // Idle with no requests, then a stray ack that must change nothing.
    for (int c = 0; c < 5; c++) begin
      step(8'h00, 1'b0);
      expect_out("idle", 0, 0, 8'h00);
    end
    step(8'h00, 1'b1);
    expect_out("idle_ack", 0, 0, 8'h00);

    // Two requesters alternate with no bubbles.
    step(8'h81, 1'b0);
    expect_out("alt_first", 1, 0, 8'h01);
    for (int c = 0; c < 4; c++) begin
      step(8'h81, 1'b1);
      expect_out("alt", 1, (c % 2 == 0) ? 7 : 0, (c % 2 == 0) ? 8'h80 : 8'h01);
    end

    // Full rotation including the 7->0 wrap.
    pulse_reset();
    step(8'hFF, 1'b0);
    expect_out("rot_first", 1, 0, 8'h01);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    for (int c = 0; c < 9; c++) begin
      step(8'hFF, 1'b1);
      expect_out("rot", 1, exp_seq[c], 1 << exp_seq[c]);
    end

    // Sticky grant while ack is low.
    pulse_reset();
    step(8'h08, 1'b0);
    expect_out("sticky_load", 1, 3, 8'h08);
    for (int c = 0; c < 4; c++) begin
      step(8'h10, 1'b0);
      expect_out("sticky_hold", 1, 3, 8'h08);
    end
    step(8'h10, 1'b1);
    expect_out("sticky_next", 1, 4, 8'h10);

    // Drain to idle, then the moved pointer decides between lines 1 and 2.
    pulse_reset();
    step(8'h04, 1'b0);
    expect_out("drain_load", 1, 2, 8'h04);
    step(8'h00, 1'b1);
    expect_out("drain_idle", 0, 0, 8'h00);
    step(8'h06, 1'b0);
    expect_out("drain_ptr", 1, 1, 8'h02);

    // Asynchronous reset in the middle of a grant.
    pulse_reset();
    step(8'h20, 1'b0);
    expect_out("mid_load", 1, 5, 8'h20);
    reset = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 8'h00);
    #1;
    reset = 1'b0;
    step(8'hFF, 1'b0);
    expect_out("after_rst", 1, 0, 8'h01);

    // Random traffic: mix of sparse and dense requests, random ack, rare resets.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step(r, 1'($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
